// File: rtl/avl_arb_pkg.sv
// Shared types for the Avalon-style register-port arbiter.
package avl_arb_pkg;

  localparam int AVL_DW  = 32;
  localparam int AVL_BEW = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic               rd;
    logic               wr;
    logic [AVL_DW-1:0]  addr;
    logic [AVL_BEW-1:0] be;
    logic [AVL_DW-1:0]  wdata;
  } avl_cmd_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester strictly after rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int IDXW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [IDXW-1:0]    grant,
  output logic               any_req
);

  logic            found;
  logic [IDXW-1:0] idx;

  assign any_req = |req;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avl_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style register port between NUM_REQ masters.
// Define AVL_ARB_TIMEOUT_EN to build the hung-access abort counter.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and launch the winner's command
// BUSY  | command held on m_*; waiting for m_ack (or timeout)
// DONE  | req_ack pulsed to the granted master; back to IDLE next cycle
module avl_bus_arbiter
  import avl_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                       clk10,
  input  logic                       rst_10,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*AVL_DW-1:0]  req_address,
  input  logic [NUM_REQ*AVL_BEW-1:0] req_byte_en,
  input  logic [NUM_REQ*AVL_DW-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [AVL_DW-1:0]          req_rdata,
  output logic                       req_error,
  output logic                       m_read,
  output logic                       m_write,
  output logic [AVL_DW-1:0]          m_address,
  output logic [AVL_BEW-1:0]         m_byte_en,
  output logic [AVL_DW-1:0]          m_wdata,
  input  logic                       m_ack,
  input  logic [AVL_DW-1:0]          m_rdata
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  avl_cmd_t           sel_cmd;
  avl_cmd_t           cmd_q;
  logic [NUM_REQ-1:0] req_vec;
  logic [IDXW-1:0]    pick;
  logic [IDXW-1:0]    grant;
  logic [IDXW-1:0]    rr_ptr;
  logic               any_req;

  assign req_vec = req_read | req_write;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (req_vec),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  // A master raising both strobes is treated as a write.
  always_comb begin
    sel_cmd.wr    = req_write[pick];
    sel_cmd.rd    = req_read[pick] & ~req_write[pick];
    sel_cmd.addr  = req_address[AVL_DW*pick +: AVL_DW];
    sel_cmd.be    = req_byte_en[AVL_BEW*pick +: AVL_BEW];
    sel_cmd.wdata = req_wdata[AVL_DW*pick +: AVL_DW];
  end

  assign m_read    = cmd_q.rd;
  assign m_write   = cmd_q.wr;
  assign m_address = cmd_q.addr;
  assign m_byte_en = cmd_q.be;
  assign m_wdata   = cmd_q.wdata;

`ifdef AVL_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;
  logic          err_q;
  assign req_error = err_q;
`else
  assign req_error = 1'b0;
`endif

  always_ff @(posedge clk10) begin
    if (rst_10) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= IDXW'(NUM_REQ - 1);
      cmd_q     <= '0;
      req_ack   <= '0;
      req_rdata <= '0;
`ifdef AVL_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ack <= '0;
          if (any_req) begin
            cmd_q  <= sel_cmd;
            grant  <= pick;
            rr_ptr <= pick;
            state  <= BUSY;
`ifdef AVL_ARB_TIMEOUT_EN
            // Down-counter: expiry is the terminal count of zero.
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        BUSY: begin
          // A real acknowledge always beats an expiry in the same cycle.
          if (m_ack) begin
            req_rdata      <= cmd_q.wr ? '0 : m_rdata;
            cmd_q.rd       <= 1'b0;
            cmd_q.wr       <= 1'b0;
            req_ack[grant] <= 1'b1;
            state          <= DONE;
`ifdef AVL_ARB_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
          end
`ifdef AVL_ARB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            req_rdata      <= TIMEOUT_DATA;
            err_q          <= 1'b1;
            cmd_q.rd       <= 1'b0;
            cmd_q.wr       <= 1'b0;
            req_ack[grant] <= 1'b1;
            state          <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        DONE: begin
          req_ack <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Scoreboard bench for avl_bus_arbiter; the timeout case follows AVL_ARB_TIMEOUT_EN.
module tb_avl_bus_arbiter;

  localparam int N = 2;

  logic            clk10 = 1'b0;
  logic            rst_10;
  logic [N-1:0]    req_read, req_write;
  logic [N*32-1:0] req_address, req_wdata;
  logic [N*4-1:0]  req_byte_en;
  logic [N-1:0]    req_ack;
  logic [31:0]     req_rdata;
  logic            req_error;
  logic            m_read, m_write;
  logic [31:0]     m_address;
  logic [3:0]      m_byte_en;
  logic [31:0]     m_wdata;
  logic            m_ack;
  logic [31:0]     m_rdata;

  avl_bus_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk10       (clk10),
    .rst_10      (rst_10),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_byte_en (req_byte_en),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .req_rdata   (req_rdata),
    .req_error   (req_error),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_byte_en   (m_byte_en),
    .m_wdata     (m_wdata),
    .m_ack       (m_ack),
    .m_rdata     (m_rdata)
  );

  always #50 clk10 = ~clk10;

  int cyc = 0;
  always @(posedge clk10) cyc <= cyc + 1;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Masters: a request stays up while issued > served; served advances on req_ack.
  int   issued[N];
  int   served[N];
  logic [N-1:0] want_wr;

  always_comb begin
    req_read  = '0;
    req_write = '0;
    for (int i = 0; i < N; i++) begin
      req_read[i]  = (issued[i] != served[i]) && !want_wr[i];
      req_write[i] = (issued[i] != served[i]) && want_wr[i];
    end
  end

  initial begin
    for (int i = 0; i < N; i++) served[i] = 0;
    forever begin
      @(negedge clk10);
      for (int i = 0; i < N; i++)
        if (req_ack[i] === 1'b1) served[i]++;
    end
  end

  // Slave: acks once the strobe has been up slave_lat cycles.
  bit          slave_en    = 1'b1;
  bit          slave_force = 1'b0;
  bit          slave_fixed = 1'b0;
  int          slave_lat   = 1;
  logic [31:0] slave_data  = '0;
  int          busy_cnt    = 0;

  initial begin
    m_ack   = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk10);
      if (m_read || m_write) busy_cnt++;
      else busy_cnt = 0;
      m_ack   = slave_force || (slave_en && busy_cnt > 0 && busy_cnt >= slave_lat);
      m_rdata = slave_force ? 32'hFFFF_FFFF :
                slave_fixed ? slave_data : {16'hC0DE, m_address[15:0]};
    end
  end

  // Monitor: every req_ack pops one expectation.
  initial begin
    forever begin
      @(negedge clk10);
      if (req_ack !== '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: got req_ack=%b, expected none", req_ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_onehot", 32'(req_ack), 32'(1 << e.m));
          chk("ack_rdata", req_rdata, e.data);
          chk("ack_error", 32'(req_error), 32'(e.err));
          ack_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input int i, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp_data, input bit exp_err);
    want_wr[i]              = wr;
    req_address[32*i +: 32] = addr;
    req_byte_en[4*i +: 4]   = be;
    req_wdata[32*i +: 32]   = wd;
    issued[i]++;
    sb.push_back('{m: i, data: exp_data, err: exp_err});
  endtask

  task automatic wait_drain(input int max_cyc);
    int k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      @(negedge clk10);
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d acks outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk10);
  endtask

  task automatic do_reset();
    @(negedge clk10);
    rst_10 = 1'b1;
    for (int i = 0; i < N; i++) issued[i] = served[i];
    @(negedge clk10);
    rst_10 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    rst_10      = 1'b1;
    want_wr     = '0;
    req_address = '0;
    req_byte_en = '0;
    req_wdata   = '0;
    for (int i = 0; i < N; i++) issued[i] = 0;
    repeat (3) @(negedge clk10);
    rst_10 = 1'b0;

    // Reset state
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_address", m_address, 32'd0);
    chk("rst_m_byte_en", 32'(m_byte_en), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_req_rdata", req_rdata, 32'd0);
    chk("rst_req_error", 32'(req_error), 32'd0);

    // 1: single read, slave acks after 2 cycles
    slave_lat   = 2;
    slave_fixed = 1'b1;
    slave_data  = 32'h1234_5678;
    @(negedge clk10);
    c0 = cyc;
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
    @(negedge clk10);
    chk("t1_m_read", 32'(m_read), 32'd1);
    chk("t1_m_address", m_address, 32'h10);
    wait_drain(20);
    chk("t1_latency", ack_cyc[$] - c0, 32'd3);
    slave_fixed = 1'b0;

    // 2: both masters continuously, 1-cycle slave; grants 0,1,0,1
    do_reset();
    slave_lat = 1;
    @(negedge clk10);
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0, 32'hC0DE_0100, 1'b0);
    issue(1, 1'b0, 32'h104, 4'hF, 32'h0, 32'hC0DE_0104, 1'b0);
    issued[0]++;
    issued[1]++;
    sb.push_back('{m: 0, data: 32'hC0DE_0100, err: 1'b0});
    sb.push_back('{m: 1, data: 32'hC0DE_0104, err: 1'b0});
    wait_drain(40);
    n = ack_cyc.size();
    for (int k = 1; k < 4; k++)
      chk("t2_ack_spacing", ack_cyc[n-4+k] - ack_cyc[n-5+k], 32'd3);

    // 3: write from master 1, command stable while BUSY
    slave_lat = 3;
    @(negedge clk10);
    issue(1, 1'b1, 32'h20, 4'b0011, 32'hA5A5_A5A5, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk10);
      chk("t3_m_write", 32'(m_write), 32'd1);
      chk("t3_m_read", 32'(m_read), 32'd0);
      chk("t3_m_address", m_address, 32'h20);
      chk("t3_m_byte_en", 32'(m_byte_en), 32'h3);
      chk("t3_m_wdata", m_wdata, 32'hA5A5_A5A5);
    end
    wait_drain(20);

    // 4: hung slave, then ack on the expiry cycle
    slave_en = 1'b0;
    @(negedge clk10);
    c0 = cyc;
`ifdef AVL_ARB_TIMEOUT_EN
    issue(0, 1'b0, 32'h40, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    repeat (8) @(negedge clk10);
    chk("t4_m_read_last_busy", 32'(m_read), 32'd1);
    @(negedge clk10);
    chk("t4_m_read_dropped", 32'(m_read), 32'd0);
    wait_drain(10);
    chk("t4_timeout_latency", ack_cyc[$] - c0, 32'd9);
`else
    issue(0, 1'b0, 32'h40, 4'hF, 32'h0, 32'hC0DE_0040, 1'b0);
    repeat (20) @(negedge clk10);
    chk("t4_m_read_still_waiting", 32'(m_read), 32'd1);
    slave_en = 1'b1;
    wait_drain(10);
`endif
    slave_en  = 1'b1;
    slave_lat = 8;
    @(negedge clk10);
    c0 = cyc;
    issue(0, 1'b0, 32'h44, 4'hF, 32'h0, 32'hC0DE_0044, 1'b0);
    wait_drain(20);
    chk("t4_expiry_ack_latency", ack_cyc[$] - c0, 32'd9);

    // 5: reset mid-BUSY drops the access; master 0 wins first afterwards
    slave_en = 1'b0;
    @(negedge clk10);
    issue(0, 1'b0, 32'h50, 4'hF, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk10);
    chk("t5_busy_before_rst", 32'(m_read), 32'd1);
    rst_10 = 1'b1;
    sb.delete();
    @(negedge clk10);
    rst_10 = 1'b0;
    chk("t5_rst_m_read", 32'(m_read), 32'd0);
    chk("t5_rst_m_address", m_address, 32'd0);
    chk("t5_rst_req_ack", 32'(req_ack), 32'd0);
    chk("t5_rst_req_rdata", req_rdata, 32'd0);
    slave_lat = 1;
    slave_en  = 1'b1;
    sb.push_back('{m: 0, data: 32'hC0DE_0050, err: 1'b0});
    issue(1, 1'b0, 32'h58, 4'hF, 32'h0, 32'hC0DE_0058, 1'b0);
    wait_drain(20);

    // 6: spurious m_ack in IDLE
    slave_force = 1'b1;
    repeat (3) @(negedge clk10);
    slave_force = 1'b0;
    repeat (2) @(negedge clk10);
    chk("t6_rdata_held", req_rdata, 32'hC0DE_0058);
    chk("t6_m_read_idle", 32'(m_read), 32'd0);
    chk("t6_m_write_idle", 32'(m_write), 32'd0);
    issue(0, 1'b0, 32'h60, 4'hF, 32'h0, 32'hC0DE_0060, 1'b0);
    @(negedge clk10);
    chk("t6_still_idle_launch", 32'(m_read), 32'd1);
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
